adder_accum_ctrl: RTL and testbench
===================================

# adder_accum_ctrl

Sequential operand feeder and result collector wrapped around the existing combinational `full_adder_32bit` datapath. It accepts a valid/ready stream of N-bit words grouped into packets by a `last` flag. Each word is added into an accumulator register through the ripple adder, one word per cycle. At packet end it presents the total, a sticky overflow flag and the word count on a valid/ready output port.

## Interface
- `N`, default 32: data width; must match the adder instance width.
- `CNT_W`, default 8: width of the word counter.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: input word valid.
- `in_ready_o` out 1: block can accept a word (registered).
- `in_data_i` in N: input operand.
- `in_last_i` in 1: the word is the final word of its packet.
- `out_valid_o` out 1: result valid (registered).
- `out_ready_i` in 1: downstream accepts the result.
- `out_sum_o` out N: accumulated sum (accumulator register).
- `out_ovf_o` out 1: sticky carry-out or overflow seen within the packet.
- `out_cnt_o` out CNT_W: number of words in the packet, saturating.
- `busy_o` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- Adder connections:
  - `a` = accumulator.
  - `b` = `in_data_i`.
  - `c` = 0.
- Accept condition: `in_valid_i && in_ready_o`.
- IDLE (accumulator = 0):
  - On accept: acc <= sum; cnt <= 1; ovf <= cout.
  - Next state is DONE if `in_last_i`, else ACCUM.
- ACCUM:
  - On accept: acc <= sum; cnt <= cnt+1, saturating at 2^CNT_W−1; ovf <= ovf | cout.
  - On `in_last_i`, go to DONE.
  - With no accept, hold all state.
- DONE:
  - `out_valid_o` = 1 and `in_ready_o` = 0.
  - Sum, ovf and cnt hold stable while `out_ready_i` = 0.
  - On `out_ready_i`: acc, cnt and ovf <= 0, then go to IDLE.
- `busy_o` = 1 in ACCUM and DONE.
- Arithmetic is modulo 2^N by default; the carry out of the MSB is the only overflow source (unsigned).
- `in_data_i` is ignored whenever no accept occurs.

## Timing
- Reset values: state IDLE; acc 0; cnt 0; ovf 0; `in_ready_o` 0; `out_valid_o` 0; `busy_o` 0.
- `in_ready_o` rises on the first rising edge after `rst_ni` deasserts.
- Throughput is one word per cycle within a packet.
- Latency: when the last word is accepted at edge k, `out_valid_o` = 1 in the cycle following edge k, carrying the sum that includes that word.
- `in_ready_o` falls at the same edge k and rises at the edge of the output handshake. This gives a minimum one-cycle bubble between packets.
- Single-word packet (IDLE accept with `last` = 1): the result is the word itself, with cnt = 1.
- The counter saturates; it never wraps to 0.
- Reset asserted mid-packet or in DONE: all state returns to reset values immediately (asynchronous). The partial packet is discarded and no output is produced.
- The adder critical path (N-bit ripple) sits between the acc register and the acc register and must close in one cycle.

## Configuration
- `ACCUM_SATURATE_EN` defined:
  - On any cout = 1, acc <= all-ones (2^N−1).
  - Once saturated, acc stays all-ones for the rest of the packet.
  - ovf behaves as in the default mode.
- Not defined: acc wraps modulo 2^N; ovf is still sticky.

## Structure
- Shared package `adder_pkg`:
  - `accum_state_e` enum (IDLE, ACCUM, DONE).
  - Default width constants `ADDER_N` = 32 and `ACCUM_CNT_W` = 8.
- One sub-module: an instance of `full_adder_32bit` with `#(N)` as the sole arithmetic datapath. No other adder is inferred in this block.
- The counter increment is local logic, not part of the adder.

## Test plan
- Reset then single word: send 0x0000_0005 with `last` → `out_sum_o` = 5, `out_cnt_o` = 1, `out_ovf_o` = 0. `out_valid_o` rises the cycle after the accept.
- Back-to-back packet: send 1, 2, 3, 4 (last on 4), valid every cycle → accepted in 4 consecutive cycles; sum = 10, cnt = 4; `in_ready_o` low exactly while DONE.
- Overflow: send 0xFFFF_FFFF then 0x0000_0002 (last):
  - Default build → sum = 0x0000_0001, ovf = 1.
  - `ACCUM_SATURATE_EN` build → sum = 0xFFFF_FFFF, ovf = 1.
- Output backpressure: hold `out_ready_i` = 0 for 5 cycles after DONE → outputs stable, no input accepted. Release → one handshake, then IDLE with `in_ready_o` = 1 on the next cycle.
- Counter saturation with `CNT_W` = 2: send 6 words of value 1 → cnt = 3, sum = 6.
- Reset mid-packet: send 7, 8, assert `rst_ni` = 0 before `last` → outputs return to reset values immediately. A following packet {9 with last} yields sum = 9, cnt = 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default widths for the accumulator controller and its adder.
package adder_pkg;

  localparam int unsigned ADDER_N     = 32;
  localparam int unsigned ACCUM_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_e;

endpackage

// File: rtl/adder_accum_ctrl_if.sv
// Input word stream and result stream of adder_accum_ctrl, grouped with master/slave views.
interface adder_accum_ctrl_if
  import adder_pkg::*;
#(
  parameter int unsigned N     = ADDER_N,
  parameter int unsigned CNT_W = ACCUM_CNT_W
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [N-1:0]     in_data_i;
  logic             in_last_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [N-1:0]     out_sum_o;
  logic             out_ovf_o;
  logic [CNT_W-1:0] out_cnt_o;
  logic             busy_o;

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sum_o, out_ovf_o, out_cnt_o, busy_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sum_o, out_ovf_o, out_cnt_o, busy_o
  );

endinterface

// File: rtl/adder_accum_ctrl_full_adder.sv
// Combinational N-bit ripple-carry adder (full_adder_32bit), the sole arithmetic datapath.
module full_adder_32bit #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = c;

  for (genvar i = 0; i < int'(N); i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/adder_accum_ctrl.sv
// Packet accumulator: sums a valid/ready word stream per packet through a ripple adder.
// Optional ACCUM_SATURATE_EN clamps the accumulator to all-ones on carry-out.
module adder_accum_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned N     = ADDER_N,
  parameter int unsigned CNT_W = ACCUM_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  adder_accum_ctrl_if.slave  bus
);

  accum_state_e     state_q, state_d;
  logic [N-1:0]     acc_q, acc_d, acc_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [N-1:0]     sum;
  logic             cout;
  logic             accept;

  full_adder_32bit #(.N(N)) u_adder (
    .a    (acc_q),
    .b    (bus.in_data_i),
    .c    (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign accept = bus.in_valid_i && ready_q;

`ifdef ACCUM_SATURATE_EN
  // A carry now or earlier in the packet pins the accumulator at all-ones.
  assign acc_new = (cout || ovf_q) ? {N{1'b1}} : sum;
`else
  assign acc_new = sum;
`endif

  // Next-state, datapath update and registered-output next values.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = acc_new;
          cnt_d   = CNT_W'(1);
          ovf_d   = cout;
          state_d = bus.in_last_i ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d = ovf_q | cout;
          if (bus.in_last_i) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != DONE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready_o  = ready_q;
  assign bus.out_valid_o = valid_q;
  assign bus.out_sum_o   = acc_q;
  assign bus.out_ovf_o   = ovf_q;
  assign bus.out_cnt_o   = cnt_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Self-checking bench for adder_accum_ctrl: directed vector table, corner sequences, random packets.
module tb_adder_accum_ctrl;

  localparam int unsigned N   = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned CW2 = 2;
`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_accum_ctrl_if #(.N(N), .CNT_W(CW))  bus ();
  adder_accum_ctrl_if #(.N(N), .CNT_W(CW2)) bus2 ();

  adder_accum_ctrl #(.N(N), .CNT_W(CW))  dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  adder_accum_ctrl #(.N(N), .CNT_W(CW2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;
  int cyc      = 0;

  always @(posedge clk) begin
    cyc++;
    if (bus.in_valid_i && bus.in_ready_o) accepts++;
  end

  typedef struct {
    int unsigned nw;
    logic [31:0] w[6];
    logic [31:0] s;
    logic        o;
    logic [7:0]  c;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_sum"},   64'(bus.out_sum_o),   64'd0);
    chk({name, "_cnt"},   64'(bus.out_cnt_o),   64'd0);
    chk({name, "_ovf"},   64'(bus.out_ovf_o),   64'd0);
    chk({name, "_ready"}, 64'(bus.in_ready_o),  64'd0);
    chk({name, "_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({name, "_busy"},  64'(bus.busy_o),      64'd0);
  endtask

  // Reference: unsigned packet sum with sticky carry, optional clamp, saturating count.
  task automatic model(input logic [31:0] ws[$], output logic [31:0] s, output logic o,
                       output logic [7:0] c);
    longint unsigned t = 0;
    o = 1'b0;
    foreach (ws[i]) begin
      t = t + longint'(ws[i]);
      if (t > 64'h0000_0000_FFFF_FFFF) begin
        o = 1'b1;
        t = SAT ? 64'h0000_0000_FFFF_FFFF : (t & 64'h0000_0000_FFFF_FFFF);
      end
    end
    s = 32'(t);
    c = (ws.size() > 255) ? 8'd255 : 8'(ws.size());
  endtask

  task automatic send_word(input logic [31:0] d, input bit l, input int gap);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = $urandom;
      bus.in_last_i  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.in_last_i  = l;
    while (!bus.in_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] ws[$], input int gapmax);
    foreach (ws[i]) send_word(ws[i], (i == ws.size() - 1), $urandom_range(0, gapmax));
  endtask

  task automatic collect(input string name, input logic [31:0] es, input logic eo,
                         input logic [7:0] ec, input int delay);
    int n = 0;
    chk({name, "_latency"}, 64'(bus.out_valid_o), 64'd1);
    while (!bus.out_valid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
    end
    chk({name, "_sum"},      64'(bus.out_sum_o),  64'(es));
    chk({name, "_ovf"},      64'(bus.out_ovf_o),  64'(eo));
    chk({name, "_cnt"},      64'(bus.out_cnt_o),  64'(ec));
    chk({name, "_rdy_done"}, 64'(bus.in_ready_o), 64'd0);
    chk({name, "_busy"},     64'(bus.busy_o),     64'd1);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk({name, "_valid_clr"}, 64'(bus.out_valid_o), 64'd0);
    chk({name, "_rdy_back"},  64'(bus.in_ready_o),  64'd1);
    chk({name, "_idle"},      64'(bus.busy_o),      64'd0);
  endtask

  initial begin
    vec_t        vt[6];
    logic [31:0] q[$];
    logic [31:0] es;
    logic        eo;
    logic [7:0]  ec;
    int          start, acc0;

    vt[0] = '{nw: 1, w: '{32'h5, 0, 0, 0, 0, 0}, s: 32'h5, o: 1'b0, c: 8'd1, name: "single"};
    vt[1] = '{nw: 4, w: '{32'd1, 32'd2, 32'd3, 32'd4, 0, 0}, s: 32'd10, o: 1'b0, c: 8'd4,
              name: "b2b"};
    vt[2] = '{nw: 2, w: '{32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0},
              s: SAT ? 32'hFFFF_FFFF : 32'h1, o: 1'b1, c: 8'd2, name: "ovf"};
    vt[3] = '{nw: 1, w: '{32'h0, 0, 0, 0, 0, 0}, s: 32'h0, o: 1'b0, c: 8'd1, name: "zero"};
    vt[4] = '{nw: 3, w: '{32'h8000_0000, 32'h8000_0000, 32'h3, 0, 0, 0},
              s: SAT ? 32'hFFFF_FFFF : 32'h3, o: 1'b1, c: 8'd3, name: "ovf_mid"};
    vt[5] = '{nw: 2, w: '{32'hFFFF_FFFE, 32'h1, 0, 0, 0, 0}, s: 32'hFFFF_FFFF, o: 1'b0,
              c: 8'd2, name: "max_no_ovf"};

    rst_n = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_last_i = 1'b0; bus.out_ready_i = 1'b0;
    bus2.in_valid_i = 1'b0; bus2.in_data_i = '0; bus2.in_last_i = 1'b0; bus2.out_ready_i = 1'b0;
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(bus.in_ready_o), 64'd1);

    // Directed vectors, words offered every cycle.
    foreach (vt[v]) begin
      start = cyc;
      acc0  = accepts;
      for (int i = 0; i < int'(vt[v].nw); i++)
        send_word(vt[v].w[i], (i == int'(vt[v].nw) - 1), 0);
      chk({vt[v].name, "_cycles"},  64'(cyc - start),     64'(vt[v].nw));
      chk({vt[v].name, "_accepts"}, 64'(accepts - acc0),  64'(vt[v].nw));
      collect(vt[v].name, vt[v].s, vt[v].o, vt[v].c, 0);
    end

    // Output backpressure with input traffic offered during DONE.
    q = '{32'd10, 32'd20};
    send_packet(q, 0);
    acc0 = accepts;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(bus.out_valid_o), 64'd1);
      chk("bp_sum",   64'(bus.out_sum_o),   64'd30);
      chk("bp_cnt",   64'(bus.out_cnt_o),   64'd2);
      chk("bp_ready", 64'(bus.in_ready_o),  64'd0);
    end
    bus.in_valid_i = 1'b0;
    chk("bp_no_accept", 64'(accepts - acc0), 64'd0);
    collect("bp", 32'd30, 1'b0, 8'd2, 0);

    // Reset in the middle of a packet discards it.
    send_word(32'd7, 1'b0, 0);
    send_word(32'd8, 1'b0, 0);
    chk("mid_busy", 64'(bus.busy_o),    64'd1);
    chk("mid_sum",  64'(bus.out_sum_o), 64'd15);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_ready", 64'(bus.in_ready_o), 64'd1);
    send_word(32'd9, 1'b1, 0);
    collect("post_rst", 32'd9, 1'b0, 8'd1, 0);

    // Counter saturation on the narrow-counter instance.
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      bus2.in_valid_i = 1'b1;
      bus2.in_data_i  = 32'd1;
      bus2.in_last_i  = (i == 5);
      while (!bus2.in_ready_o && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) chk("sat2_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    bus2.in_valid_i = 1'b0;
    bus2.in_last_i  = 1'b0;
    chk("cnt2_valid", 64'(bus2.out_valid_o), 64'd1);
    chk("cnt2_cnt",   64'(bus2.out_cnt_o),   64'd3);
    chk("cnt2_sum",   64'(bus2.out_sum_o),   64'd6);
    chk("cnt2_ovf",   64'(bus2.out_ovf_o),   64'd0);
    bus2.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready_i = 1'b0;
    chk("cnt2_idle", 64'(bus2.busy_o), 64'd0);

    // Random packets against the reference model.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = (p == 20) ? 300 : $urandom_range(1, 12);
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom));
      model(q, es, eo, ec);
      send_packet(q, 2);
      collect($sformatf("rnd%0d", p), es, eo, ec, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
